// File: rtl/dff_din_conditioner.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// dff_din_conditioner
//
// Input stage for the D flip-flop cells. It takes a raw asynchronous level
// (switch, off-chip pin) and produces a clean, debounced level in the clk
// domain. It also produces a one-cycle pulse whenever that level changes.
//
// Parameters
//   SYNC_STAGES      synchronizer depth on d_async (>= 2)
//   DEBOUNCE_CYCLES  consecutive synchronized cycles a new level must hold
//                    before it is accepted (>= 2)
//   RST_VAL          reset level of the synchronizer chain and of q
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-low
//   en       in   1 = qualification advances, 0 = FSM/counter/q frozen
//   d_async  in   raw asynchronous level
//   q        out  debounced level (registered)
//   q_en     out  one-cycle pulse in the cycle q changes
//   rise     out  one-cycle pulse on an accepted 0->1
//   fall     out  one-cycle pulse on an accepted 1->0
//   busy     out  high while a candidate level is being qualified
// -----------------------------------------------------------------------------
module dff_din_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d_async,
    output logic q,
    output logic q_en,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    // Parameter legality is checked at elaboration.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("dff_din_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
        $error("dff_din_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        StStableLo,
        StPendHi,
        StStableHi,
        StPendLo
    } state_e;

    localparam state_e StReset = RST_VAL ? StStableHi : StStableLo;

    // -------------------------------------------------------------------------
    // Synchronizer. The chain keeps shifting even while en=0, so the FSM sees
    // a fresh level as soon as it is re-enabled.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
        end
    end

    assign d_s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debounce FSM: state register
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             q_en_q, q_en_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StReset;
            cnt_q   <= '0;
            q_q     <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            q_en_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            q_en_q  <= q_en_d;
            busy_q  <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM: next state and registered-output next values.
    // Entering a PEND state counts as the first qualified cycle (cnt=1), so a
    // candidate is accepted after DEBOUNCE_CYCLES consecutive matching cycles.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (en) begin
            unique case (state_q)
                StStableLo: begin
                    if (d_s) begin
                        state_d = StPendHi;
                        cnt_d   = CntOne;
                    end
                end

                StPendHi: begin
                    if (!d_s) begin
                        // Glitch: candidate dropped before it qualified.
                        state_d = StStableLo;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StStableHi;
                        cnt_d   = '0;
                        q_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end

                StStableHi: begin
                    if (!d_s) begin
                        state_d = StPendLo;
                        cnt_d   = CntOne;
                    end
                end

                StPendLo: begin
                    if (d_s) begin
                        state_d = StStableHi;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StStableLo;
                        cnt_d   = '0;
                        q_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end

                default: begin
                    state_d = StReset;
                    cnt_d   = '0;
                end
            endcase
        end

        q_en_d = rise_d | fall_d;
        busy_d = (state_d == StPendHi) || (state_d == StPendLo);
    end

    assign q    = q_q;
    assign q_en = q_en_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dff_din_conditioner.sv
`timescale 1ns / 1ps
// Directed bench for dff_din_conditioner: default instance (RST_VAL=0) and a
// second instance with RST_VAL=1. Outputs are sampled 0.5 ns after each edge.
module tb_dff_din_conditioner;

    logic clk;
    logic en;
    logic rst0, d0, q0, q_en0, rise0, fall0, busy0;
    logic rst1, d1, q1, q_en1, rise1, fall1, busy1;

    int n_checks;
    int n_errors;

    dff_din_conditioner u_dut0 (
        .clk     (clk),
        .rst     (rst0),
        .en      (en),
        .d_async (d0),
        .q       (q0),
        .q_en    (q_en0),
        .rise    (rise0),
        .fall    (fall0),
        .busy    (busy0)
    );

    dff_din_conditioner #(
        .RST_VAL (1'b1)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst1),
        .en      (en),
        .d_async (d1),
        .q       (q1),
        .q_en    (q_en1),
        .rise    (rise1),
        .fall    (fall1),
        .busy    (busy1)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Checks edges k0..k1 of a sequence. q changes from q_from to q_to at edge
    // 'hit' (-1 = never), with a single pulse there; busy expected on blo..bhi.
    task automatic watch(input string tag, input int sel, input int k0, input int k1,
                         input int hit, input logic q_from, input logic q_to,
                         input int blo, input int bhi);
        logic eq, ep, eb;
        logic gq, gqe, gr, gf, gb;
        for (int k = k0; k <= k1; k++) begin
            @(posedge clk);
            #0.5;
            eq = (hit >= 0 && k >= hit) ? q_to : q_from;
            ep = (k == hit);
            eb = (k >= blo) && (k <= bhi);
            if (sel == 0) begin
                gq = q0; gqe = q_en0; gr = rise0; gf = fall0; gb = busy0;
            end else begin
                gq = q1; gqe = q_en1; gr = rise1; gf = fall1; gb = busy1;
            end
            check_eq($sformatf("%s q e%0d", tag, k), gq, eq);
            check_eq($sformatf("%s q_en e%0d", tag, k), gqe, ep);
            check_eq($sformatf("%s rise e%0d", tag, k), gr, ep & q_to);
            check_eq($sformatf("%s fall e%0d", tag, k), gf, ep & ~q_to);
            check_eq($sformatf("%s busy e%0d", tag, k), gb, eb);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst0 = 1'b0;
        rst1 = 1'b0;
        en   = 1'b1;
        d0   = 1'b0;
        d1   = 1'b1;

        // Reset hold: inputs toggle, outputs stay at reset values.
        for (int i = 0; i < 4; i++) begin
            #3;
            d0 = ~d0;
            d1 = ~d1;
            check_eq("hold q0", q0, 1'b0);
            check_eq("hold q_en0", q_en0, 1'b0);
            check_eq("hold rise0", rise0, 1'b0);
            check_eq("hold fall0", fall0, 1'b0);
            check_eq("hold busy0", busy0, 1'b0);
            check_eq("hold q1", q1, 1'b1);
        end

        @(posedge clk);
        #0.5;
        d0   = 1'b0;
        d1   = 1'b1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        watch("idle0", 0, 0, 3, -1, 1'b0, 1'b0, -1, -1);

        // Clean rising step: accepted at edge 5, busy on edges 2..4.
        d0 = 1'b1;
        watch("step", 0, 0, 7, 5, 1'b0, 1'b1, 2, 4);

        // Clean falling step on the default instance.
        d0 = 1'b0;
        watch("fall0", 0, 0, 7, 5, 1'b1, 1'b0, 2, 4);

        // Glitch: high for 3 cycles only, never accepted.
        d0 = 1'b1;
        watch("glitch", 0, 0, 2, -1, 1'b0, 1'b0, 2, 4);
        d0 = 1'b0;
        watch("glitch", 0, 3, 7, -1, 1'b0, 1'b0, 2, 4);

        // Enable freeze for 4 edges (3..6) delays acceptance from edge 5 to 9.
        d0 = 1'b1;
        watch("freeze", 0, 0, 2, 9, 1'b0, 1'b1, 2, 8);
        en = 1'b0;
        watch("freeze", 0, 3, 6, 9, 1'b0, 1'b1, 2, 8);
        en = 1'b1;
        watch("freeze", 0, 7, 11, 9, 1'b0, 1'b1, 2, 8);

        d0 = 1'b0;
        watch("fall0b", 0, 0, 7, 5, 1'b1, 1'b0, 2, 4);

        // RST_VAL=1 instance: starts high, falls at edge 5.
        watch("idle1", 1, 0, 1, -1, 1'b1, 1'b1, -1, -1);
        d1 = 1'b0;
        watch("fall1", 1, 0, 7, 5, 1'b1, 1'b0, 2, 4);

        // Mid-pending reset at edge 3 of a rising step.
        d0 = 1'b1;
        watch("mid", 0, 0, 3, -1, 1'b0, 1'b0, 2, 4);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #0.2;
        check_eq("mid async busy0", busy0, 1'b0);
        check_eq("mid async q0", q0, 1'b0);
        check_eq("mid async q1", q1, 1'b1);
        @(posedge clk);
        #0.5;
        check_eq("mid in-reset q_en0", q_en0, 1'b0);
        check_eq("mid in-reset busy0", busy0, 1'b0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        // d0 still 1: requalifies from scratch, accepted at edge 5 after release.
        watch("requal", 0, 0, 7, 5, 1'b0, 1'b1, 2, 4);
        // The RST_VAL=1 instance saw d1=0 throughout and fell at the same edge.
        check_eq("requal q1", q1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
